// File: rtl/dport_ctrl.sv
// dport_ctrl: memory-mapped byte FIFO that feeds a valid/ready data port.
// Status/count readback and a done flag that waits for the FIFO to drain.
module dport_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter logic [1:0]  WINDOW = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  output logic        cs,
  output logic [7:0]  data_out,
  output logic [7:0]  dport_out,
  output logic        dport_write,
  input  logic        dport_ready,
  output logic        done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DONE   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_e;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          done_req_q, done_req_d;
  logic          done_q, done_d;
  logic [7:0]    data_out_q, data_out_d;
  logic [7:0]    mem_q [DEPTH];

  reg_e reg_sel;
  logic wr_hit;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic accept;
  logic drop;
  logic ovf_clr;
  logic unused_addr;

  assign unused_addr = ^addr[13:2];

  assign cs      = (addr[15:14] == WINDOW);
  assign reg_sel = reg_e'(addr[1:0]);
  assign wr_hit  = we & cs;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = ~empty & dport_ready;
  assign push    = wr_hit & (reg_sel == REG_DATA);
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign ovf_clr = wr_hit & (reg_sel == REG_STATUS) & data_in[2];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set wins over clear when both land in one cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_comb begin
    done_req_d = done_req_q | (wr_hit & (reg_sel == REG_DONE));
    done_d     = done_req_q & empty;
  end

  always_comb begin
    data_out_d = 8'h00;
    unique case (reg_sel)
      REG_STATUS: data_out_d = {4'b0, done_req_q, overflow_q, full, empty};
      REG_COUNT:  data_out_d = 8'(count_q);
      default:    data_out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_req_q <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_req_q <= done_req_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset; dport_out is masked while empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

  assign dport_write = ~empty;
  assign dport_out   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_out    = data_out_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dport_ctrl.sv
// tb_dport_ctrl: directed scenarios plus random traffic, checked against
// a queue-based model of the register map and byte port.
module tb_dport_ctrl;

  localparam int DEPTH = 8;
  localparam logic [1:0] WINDOW = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic        cs;
  logic [7:0]  data_out;
  logic [7:0]  dport_out;
  logic        dport_write;
  logic        dport_ready;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_dreq;
  bit         m_done;
  logic [7:0] m_do;

  always #5 clk = ~clk;

  dport_ctrl #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .data_in     (data_in),
    .we          (we),
    .cs          (cs),
    .data_out    (data_out),
    .dport_out   (dport_out),
    .dport_write (dport_write),
    .dport_ready (dport_ready),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf  = 0;
    m_dreq = 0;
    m_done = 0;
    m_do   = 8'h00;
  endtask

  // One rising edge of the reference behaviour, from the current inputs.
  task automatic model_step();
    int n;
    bit hit, pop, psh, dn;
    logic [7:0] rd;
    if (rst) begin
      model_clear();
      return;
    end
    n   = q.size();
    hit = we && (addr[15:14] == WINDOW);
    pop = (n > 0) && dport_ready;
    psh = hit && (addr[1:0] == 2'd0);
    case (addr[1:0])
      2'd1:    rd = {4'b0, m_dreq, m_ovf, n == DEPTH, n == 0};
      2'd3:    rd = n[7:0];
      default: rd = 8'h00;
    endcase
    dn = m_dreq && (n == 0);
    if (hit && addr[1:0] == 2'd1 && data_in[2]) m_ovf = 0;
    if (hit && addr[1:0] == 2'd2) m_dreq = 1;
    if (pop) void'(q.pop_front());
    if (psh) begin
      if (n < DEPTH || pop) q.push_back(data_in);
      else m_ovf = 1;
    end
    m_done = dn;
    m_do   = rd;
  endtask

  task automatic check_outputs();
    check("dport_write", dport_write, q.size() != 0);
    check("dport_out", dport_out, (q.size() != 0) ? q[0] : 8'h00);
    check("done", done, m_done);
    check("data_out", data_out, m_do);
  endtask

  task automatic cyc(input logic [15:0] a, input logic [7:0] d,
                     input logic w, input logic r);
    @(negedge clk);
    check_outputs();
    addr        = a;
    data_in     = d;
    we          = w;
    dport_ready = r;
    #1 check("cs", cs, a[15:14] == WINDOW);
    @(posedge clk);
    model_step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_dport_write", dport_write, 1'b0);
    check("rst_dport_out", dport_out, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    model_clear();
    cyc(16'h4003, 8'h00, 1'b0, 1'b1);
    cyc(16'h4000, 8'h99, 1'b1, 1'b1);
    @(negedge clk);
    check_outputs();
    rst  = 1'b0;
    addr = 16'h0000;
    we   = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    rst         = 1'b1;
    addr        = 16'h0000;
    data_in     = 8'h00;
    we          = 1'b0;
    dport_ready = 1'b0;
    model_clear();
    #12;
    check("init_dport_write", dport_write, 1'b0);
    check("init_dport_out", dport_out, 8'h00);
    check("init_done", done, 1'b0);
    check("init_data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_step();

    // Streaming three bytes with the consumer always ready.
    cyc(16'h4000, 8'h41, 1'b1, 1'b1);
    #1 check("stream0", dport_out, 8'h41);
    cyc(16'h4000, 8'h42, 1'b1, 1'b1);
    #1 check("stream1", dport_out, 8'h42);
    cyc(16'h4000, 8'h43, 1'b1, 1'b1);
    #1 check("stream2", dport_out, 8'h43);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    #1 check("stream_end", dport_write, 1'b0);

    // Done waits for the drain.
    cyc(16'h4000, 8'h10, 1'b1, 1'b0);
    cyc(16'h4000, 8'h11, 1'b1, 1'b0);
    cyc(16'h4002, 8'h00, 1'b1, 1'b0);
    cyc(16'h4001, 8'h00, 1'b0, 1'b0);
    #1;
    check("done_req_bit", data_out[3], 1'b1);
    check("done_held", done, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    #1 check("done_not_yet", done, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    #1 check("done_set", done, 1'b1);

    // Asynchronous reset with bytes queued.
    for (int i = 0; i < 4; i++) cyc(16'h4000, 8'(i + 1), 1'b1, 1'b0);
    async_reset();
    cyc(16'h4003, 8'h00, 1'b0, 1'b0);
    #1;
    check("count_after_rst", data_out, 8'h00);
    check("no_emit_after_rst", dport_write, 1'b0);

    // Overflow on the ninth push.
    for (int i = 0; i < 9; i++) cyc(16'h4000, 8'(i), 1'b1, 1'b0);
    cyc(16'h4001, 8'h00, 1'b0, 1'b0);
    #1 check("status_ovf_full", data_out, 8'h06);
    cyc(16'h4003, 8'h00, 1'b0, 1'b0);
    #1 check("count_full", data_out, 8'h08);
    for (int i = 0; i < 8; i++) begin
      #1 check("drain", dport_out, 8'(i));
      cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    end
    #1 check("drain_end", dport_write, 1'b0);

    // Overflow clear through an aliased STATUS address.
    cyc(16'h7FFD, 8'h04, 1'b1, 1'b0);
    cyc(16'h4001, 8'h00, 1'b0, 1'b0);
    #1 check("ovf_cleared", data_out, 8'h01);

    // Push into a full FIFO while it pops.
    for (int i = 0; i < 8; i++) cyc(16'h4000, 8'(8'h20 + i), 1'b1, 1'b0);
    cyc(16'h4000, 8'hAA, 1'b1, 1'b1);
    cyc(16'h4001, 8'h00, 1'b0, 1'b0);
    #1 check("full_push_pop_status", data_out, 8'h02);
    cyc(16'h4003, 8'h00, 1'b0, 1'b0);
    #1 check("full_push_pop_count", data_out, 8'h08);
    for (int i = 1; i < 8; i++) begin
      #1 check("drain2", dport_out, 8'(8'h20 + i));
      cyc(16'h0000, 8'h00, 1'b0, 1'b1);
    end
    #1 check("drain2_last", dport_out, 8'hAA);
    cyc(16'h0000, 8'h00, 1'b0, 1'b1);

    // Out-of-window write.
    cyc(16'h3000, 8'h55, 1'b1, 1'b0);
    #1 check("cs_low_write", dport_write, 1'b0);

    // Random traffic with varying consumer stall rates.
    for (int blk = 0; blk < 15; blk++) begin
      int stall;
      stall = $urandom_range(0, 9);
      for (int i = 0; i < 200; i++) begin
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 3) != 0) a[15:14] = WINDOW;
        if ($urandom_range(0, 9) == 0 && a[1:0] == 2'd2) a[1:0] = 2'd0;
        cyc(a, 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) >= stall);
      end
      if (blk % 4 == 3) async_reset();
    end

    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dport_ctrl.md
DPORT_CTRL -- requirements
Module: dport_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2 to 256.
REQ-002 Parameter WINDOW, default 2'b01: value of addr[15:14] that selects this block (0x4000-0x7FFF).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 addr  input  16  core bus address.
REQ-006 data_in  input  8  core write data.
REQ-007 we  input  1  core write strobe.
REQ-008 cs  output  1  combinational select, high when addr[15:14]==WINDOW; used by the system read mux.
REQ-009 data_out  output  8  registered read data.
REQ-010 dport_out  output  8  byte at the FIFO head.
REQ-011 dport_write  output  1  valid: high when the FIFO is non-empty.
REQ-012 dport_ready  input  1  consumer accepts dport_out this cycle.
REQ-013 done  output  1  program-complete flag.

Function
REQ-014 Register decode shall use addr[1:0] only; addr[13:2] ignored (aliases).
- 0 DATA
- 1 STATUS
- 2 DONE
- 3 COUNT
REQ-015 A write (we & cs) to DATA shall push data_in into the FIFO tail at the clock edge.
REQ-016 A write to STATUS with data_in[2]=1 shall clear the overflow flag; other bits are ignored.
REQ-017 A write to DONE with any value shall set done_req; done_req is sticky until reset.
REQ-018 Writes with cs low shall have no effect.
REQ-019 Reads shall register data_out at every clock edge from the current addr, giving 1-cycle latency; data_out is registered regardless of cs.
- STATUS = {4'b0, done_req, overflow, full, empty}
- COUNT = occupancy, zero-extended or truncated to 8 bits
- DATA = 8'h00
- DONE = 8'h00
REQ-020 dport_write shall equal !empty; dport_out shall equal the head entry, and shall be 8'h00 when empty.
REQ-021 A transfer (dport_write & dport_ready) shall pop the head at the clock edge; dport_ready while empty shall have no effect.
REQ-022 A push into an empty FIFO shall appear on dport_out, with dport_write high, in the following cycle, never the same cycle.
REQ-023 A push and a pop in the same cycle shall leave occupancy unchanged; this includes when the FIFO is full, where the push is accepted.
REQ-024 A push when the FIFO is full and no pop occurs shall drop the byte, leave the FIFO unchanged, and set overflow (sticky).
REQ-025 If a push is dropped and the overflow-clear write occurs in the same cycle, overflow shall end set.
REQ-026 Pointers shall wrap modulo DEPTH; occupancy shall range 0..DEPTH, with full = (occupancy == DEPTH).
REQ-027 done shall be registered and equal done_req & empty, so it asserts only after all queued bytes have been transferred.
REQ-028 done shall assert in the cycle after both conditions hold.
REQ-029 Pushes after done_req is set shall still be accepted; done shall deassert while the FIFO is non-empty.

Reset
REQ-030 rst high shall immediately clear all state, without waiting for a clock edge: FIFO pointers, occupancy, overflow, done_req, done, and data_out.
REQ-031 While rst is high, outputs shall be: dport_write=0, dport_out=8'h00, done=0, data_out=8'h00.
REQ-032 Reset mid-transfer shall discard queued bytes; no byte shall be emitted after reset release until a new push occurs.
REQ-033 The first rising clk edge after rst falls shall behave as a normal cycle.

Verification
REQ-034 Push 0x41, 0x42, 0x43 to 0x4000 with dport_ready=1 -> dport_out 0x41, 0x42, 0x43 on consecutive cycles starting 1 cycle after the first write, then dport_write=0.
REQ-035 dport_ready=0, push 9 bytes 0x00..0x08 (DEPTH=8) -> read 0x4001 returns 0x06 (overflow, full), 0x4003 returns 0x08; drain yields 0x00..0x07 only.
REQ-036 FIFO full, dport_ready=1, simultaneous push 0xAA -> overflow stays 0, COUNT stays 8, and 0xAA is emitted last.
REQ-037 Push 0x10, 0x11 with dport_ready=0, write 0x4002 -> done=0 and STATUS bit3=1; raise dport_ready -> done=1 one cycle after the FIFO empties.
REQ-038 Assert rst asynchronously mid-clock with 4 bytes queued -> dport_write=0 and done=0 immediately; after release, COUNT reads 0x00.
REQ-039 Write to 0x7FFD (alias of STATUS) with data 0x04 after an overflow -> overflow cleared; write to 0x3000 (cs=0) -> no FIFO change.
